// File: rtl/nv_lsd_blk_norm.sv
// ---------------------------------------------------------------------------
// nv_lsd_blk_norm
//   Block-floating-point normaliser. Buffers a block of up to BLK_LEN signed
//   samples, tracks the smallest redundant-sign-bit count (enc) over the block,
//   then replays every buffered sample left-shifted by that shared count along
//   with the count itself (block exponent). Fill and drain never overlap.
//
// Ports
//   nvdla_core_clk   in   1        clock
//   nvdla_core_rstn  in   1        async reset, active low
//   in_pvld/in_prdy  in/out        input sample handshake
//   in_pd            in   A_WIDTH  input sample (signed)
//   in_plast         in   1        sample closes the block early
//   out_pvld/out_prdy out/in       output sample handshake
//   out_pd           out  A_WIDTH  buffered sample << out_shift
//   out_shift        out  SHIFT_W  shared block shift (min enc of block)
//   out_plast        out  1        last sample of the block
// ---------------------------------------------------------------------------

// Leading-sign detect: counts bits below the MSB that match the MSB, stopping
// at the first bit that differs. All-sign inputs give A_WIDTH-1.
module nv_lsd_blk_norm_lsd #(
    parameter int A_WIDTH = 8,
    parameter int SHIFT_W = 3
) (
    input  logic [A_WIDTH-1:0] i_smp,
    output logic [SHIFT_W-1:0] o_enc
);
    logic w_run;

    always_comb begin
        o_enc = '0;
        w_run = 1'b1;
        for (int b = A_WIDTH-2; b >= 0; b--) begin
            if (w_run && (i_smp[b] == i_smp[A_WIDTH-1])) o_enc = o_enc + 1'b1;
            else                                          w_run = 1'b0;
        end
    end
endmodule

module nv_lsd_blk_norm #(
    parameter int A_WIDTH = 8,
    parameter int BLK_LEN = 4,
    parameter int SHIFT_W = 3
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic               in_pvld,
    output logic               in_prdy,
    input  logic [A_WIDTH-1:0] in_pd,
    input  logic               in_plast,
    output logic               out_pvld,
    input  logic               out_prdy,
    output logic [A_WIDTH-1:0] out_pd,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_plast
);
    localparam int IDX_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam int LEN_W = $clog2(BLK_LEN + 1);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]                      r_state;
    logic [IDX_W-1:0]                r_wr_cnt;
    logic [IDX_W-1:0]                r_rd_cnt;
    logic [LEN_W-1:0]                r_len;
    logic [SHIFT_W-1:0]              r_min_enc;
    logic [BLK_LEN-1:0][A_WIDTH-1:0] r_buf;

    logic [SHIFT_W-1:0] w_enc;
    logic               w_acc_in;
    logic               w_acc_out;
    logic               w_wr_last;
    logic               w_rd_last;

    nv_lsd_blk_norm_lsd #(
        .A_WIDTH (A_WIDTH),
        .SHIFT_W (SHIFT_W)
    ) u_lsd (
        .i_smp (in_pd),
        .o_enc (w_enc)
    );

    assign in_prdy   = (r_state == ST_FILL);
    assign out_pvld  = (r_state == ST_DRAIN);
    assign w_acc_in  = in_pvld  & in_prdy;
    assign w_acc_out = out_pvld & out_prdy;

    assign w_wr_last = (r_wr_cnt == IDX_W'(BLK_LEN-1)) || in_plast;
    assign w_rd_last = (LEN_W'(r_rd_cnt) == (r_len - LEN_W'(1)));

    // Shifting by the block minimum only discards redundant sign bits, so the
    // sign of every sample survives the logical left shift.
    assign out_pd    = r_buf[r_rd_cnt] << r_min_enc;
    assign out_shift = r_min_enc;
    assign out_plast = out_pvld & w_rd_last;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state   <= ST_FILL;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_len     <= '0;
            r_min_enc <= SHIFT_W'(A_WIDTH-1);
            r_buf     <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_acc_in) begin
                        r_buf[r_wr_cnt] <= in_pd;
                        r_wr_cnt        <= r_wr_cnt + 1'b1;
                        // First sample of a block seeds the minimum.
                        if (r_wr_cnt == '0 || w_enc < r_min_enc) r_min_enc <= w_enc;
                        if (w_wr_last) begin
                            r_len   <= LEN_W'(r_wr_cnt) + LEN_W'(1);
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                default: begin
                    if (w_acc_out) begin
                        if (w_rd_last) begin
                            r_rd_cnt <= '0;
                            r_wr_cnt <= '0;
                            r_state  <= ST_FILL;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nv_lsd_blk_norm.sv
// ---------------------------------------------------------------------------
// tb_nv_lsd_blk_norm
//   Directed blocks with hand-computed results, a reset-mid-block case and a
//   randomized stream scored against a block-level reference model.
// ---------------------------------------------------------------------------
module tb_nv_lsd_blk_norm;
    localparam int AW = 8;
    localparam int BL = 4;
    localparam int SW = 3;

    typedef logic [SW+AW:0] exp_t;   // {plast, shift, pd}

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_pvld = 1'b0;
    logic          in_prdy;
    logic [AW-1:0] in_pd = '0;
    logic          in_plast = 1'b0;
    logic          out_pvld;
    logic          out_prdy = 1'b1;
    logic [AW-1:0] out_pd;
    logic [SW-1:0] out_shift;
    logic          out_plast;

    always #5 clk = ~clk;

    nv_lsd_blk_norm #(.A_WIDTH(AW), .BLK_LEN(BL), .SHIFT_W(SW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .in_pvld         (in_pvld),
        .in_prdy         (in_prdy),
        .in_pd           (in_pd),
        .in_plast        (in_plast),
        .out_pvld        (out_pvld),
        .out_prdy        (out_prdy),
        .out_pd          (out_pd),
        .out_shift       (out_shift),
        .out_plast       (out_plast)
    );

    exp_t          exp_q[$];
    logic [AW:0]   stim_q[$];   // {plast, data}
    logic [AW-1:0] blk_q[$];
    int  n_chk = 0, n_err = 0;
    int  prdy_mode = 0, hold_cnt = 0, out_idx = 0, low_cnt = 0;
    bit  use_model = 0, gap_en = 0, acc_in = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    // Largest k such that shifting left by k and arithmetically back restores x.
    function automatic int enc_of(input logic [AW-1:0] x);
        logic signed [AW-1:0] s;
        for (int k = AW-1; k > 0; k--) begin
            s = x << k;
            s = s >>> k;
            if (s == x) return k;
        end
        return 0;
    endfunction

    function automatic exp_t mk(input bit pl, input int sh, input int pd);
        return {pl, SW'(sh), AW'(pd)};
    endfunction

    task automatic model_block();
        int k;
        logic [AW-1:0] v;
        k = AW-1;
        foreach (blk_q[i]) if (enc_of(blk_q[i]) < k) k = enc_of(blk_q[i]);
        foreach (blk_q[i]) begin
            v = blk_q[i] << k;
            exp_q.push_back(mk(i == blk_q.size()-1, k, v));
        end
    endtask

    task automatic push(input logic [AW-1:0] d, input bit pl);
        stim_q.push_back({pl, d});
    endtask

    task automatic monitor();
        exp_t e;
        if (!rstn) begin
            acc_in = 0;
            return;
        end
        chk("prdy_vs_vld", in_prdy, !out_pvld);
        if (!in_prdy) low_cnt++;
        if (out_pvld) begin
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                e = exp_q[0];
                chk("out_pd",    out_pd,    e[AW-1:0]);
                chk("out_shift", out_shift, e[AW+SW-1:AW]);
                chk("out_plast", out_plast, e[AW+SW]);
                if (out_prdy) begin
                    void'(exp_q.pop_front());
                    out_idx = e[AW+SW] ? 0 : out_idx + 1;
                end
            end
        end
        acc_in = in_pvld && in_prdy;
        if (acc_in) begin
            blk_q.push_back(in_pd);
            if (in_plast || blk_q.size() == BL) begin
                if (use_model) model_block();
                blk_q.delete();
            end
        end
    endtask

    task automatic drive();
        if (acc_in) void'(stim_q.pop_front());
        if (stim_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
            in_pvld  = 1'b1;
            in_plast = stim_q[0][AW];
            in_pd    = stim_q[0][AW-1:0];
        end else begin
            in_pvld  = 1'b0;
            in_plast = 1'($urandom);
            in_pd    = AW'($urandom);
        end
        case (prdy_mode)
            0: out_prdy = 1'b1;
            1: out_prdy = ($urandom_range(0, 3) != 0);
            default: begin
                if (out_pvld && out_idx == 1 && hold_cnt < 5) begin
                    out_prdy = 1'b0;
                    hold_cnt++;
                end else out_prdy = 1'b1;
            end
        endcase
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0 || out_pvld) && n < max) begin
            cyc();
            n++;
        end
        if (n >= max) chk("timeout", 1, 0);
    endtask

    task automatic push_exp_pass(input logic [AW-1:0] a, b, c, d);
        exp_q.push_back(mk(0, 0, a));
        exp_q.push_back(mk(0, 0, b));
        exp_q.push_back(mk(0, 0, c));
        exp_q.push_back(mk(1, 0, d));
    endtask

    initial begin
        int n;
        logic signed [AW-1:0] r;

        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_out_pvld",  out_pvld,  0);
        chk("rst_in_prdy",   in_prdy,   1);
        chk("rst_out_plast", out_plast, 0);
        chk("rst_out_shift", out_shift, AW-1);
        chk("rst_out_pd",    out_pd,    0);

        // Mixed block, min enc from 0x10.
        push(8'h03, 0); push(8'hFE, 0); push(8'h10, 0); push(8'h00, 0);
        exp_q.push_back(mk(0, 2, 8'h0C)); exp_q.push_back(mk(0, 2, 8'hF8));
        exp_q.push_back(mk(0, 2, 8'h40)); exp_q.push_back(mk(1, 2, 8'h00));
        run_idle(100);

        // Short block closed by in_plast: enc(0x01)=6, enc(0x02)=5.
        low_cnt = 0;
        push(8'h01, 0); push(8'h02, 1);
        exp_q.push_back(mk(0, 5, 8'h20)); exp_q.push_back(mk(1, 5, 8'h40));
        run_idle(100);
        chk("drain_prdy_low", low_cnt, 2);

        // All-sign blocks.
        for (int i = 0; i < 4; i++) begin push(8'h00, 0); exp_q.push_back(mk(i == 3, 7, 8'h00)); end
        run_idle(100);
        for (int i = 0; i < 3; i++) push(8'hFF, 0);
        push(8'hFF, 1);   // plast on the BLK_LEN-th sample
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(i == 3, 7, 8'h80));
        run_idle(100);

        // enc=0 anywhere forces pass-through.
        push(8'h80, 0); push(8'h01, 0); push(8'h01, 0); push(8'h01, 0);
        push_exp_pass(8'h80, 8'h01, 8'h01, 8'h01);
        run_idle(100);
        push(8'h7F, 0); push(8'h00, 0); push(8'hFF, 0); push(8'h40, 0);
        push_exp_pass(8'h7F, 8'h00, 8'hFF, 8'h40);
        run_idle(100);

        // Back-pressure on the second output for 5 cycles.
        prdy_mode = 2; hold_cnt = 0;
        push(8'h03, 0); push(8'hFE, 0); push(8'h10, 0); push(8'h00, 0);
        exp_q.push_back(mk(0, 2, 8'h0C)); exp_q.push_back(mk(0, 2, 8'hF8));
        exp_q.push_back(mk(0, 2, 8'h40)); exp_q.push_back(mk(1, 2, 8'h00));
        run_idle(100);
        chk("stall_cycles", hold_cnt, 5);
        prdy_mode = 0;

        // Reset mid-block discards the partial block.
        push(8'h11, 0); push(8'h22, 0);
        n = 0;
        while (stim_q.size() > 0 && n < 50) begin cyc(); n++; end
        if (n >= 50) chk("timeout_fill", 1, 0);
        rstn = 1'b0;
        blk_q.delete();
        repeat (2) cyc();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst2_out_pvld", out_pvld, 0);
        chk("rst2_in_prdy",  in_prdy,  1);
        push(8'h04, 1);
        exp_q.push_back(mk(1, 4, 8'h40));
        run_idle(100);

        // Randomized stream against the reference model.
        use_model = 1; gap_en = 1; prdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            r = AW'($urandom);
            r = r >>> $urandom_range(0, 7);
            push(r, (i == 299) || ($urandom_range(0, 4) == 0));
        end
        run_idle(5000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
